// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer tile sequencer and the data movers:
// sequencer states, default layer geometry and external-memory address helpers.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COMP  = 3'd2,
    ST_STORE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } tile_state_t;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_N  = 16;
  localparam int unsigned DEF_M  = 16;
  localparam int unsigned DEF_R  = 64;
  localparam int unsigned DEF_C  = 16;
  localparam int unsigned DEF_TN = 16;
  localparam int unsigned DEF_TM = 16;
  localparam int unsigned DEF_TR = 64;
  localparam int unsigned DEF_TC = 16;
  localparam int unsigned DEF_K  = 3;

  // Wide enough for any practical AW; callers truncate to their own width,
  // which yields the same value as computing modulo 2^AW directly.
  typedef logic [63:0] addr_calc_t;

  // Number of tiles along one dimension.
  function automatic int unsigned tile_count(input int unsigned full, input int unsigned tile);
    return full / tile;
  endfunction

  // Input feature map word offset of tile origin (m, r, c).
  function automatic addr_calc_t in_fm_addr(input addr_calc_t m, input addr_calc_t r,
                                            input addr_calc_t c, input int unsigned rows,
                                            input int unsigned cols);
    return (m * addr_calc_t'(rows) + r) * addr_calc_t'(cols) + c;
  endfunction

  // Weight word offset of tile origin (n, m); each (n, m) pair owns a K x K kernel.
  function automatic addr_calc_t weight_addr(input addr_calc_t n, input addr_calc_t m,
                                             input int unsigned in_ch, input int unsigned k);
    return (n * addr_calc_t'(in_ch) + m) * addr_calc_t'(k) * addr_calc_t'(k);
  endfunction

  // Output feature map word offset of tile origin (n, r, c).
  function automatic addr_calc_t out_fm_addr(input addr_calc_t n, input addr_calc_t r,
                                             input addr_calc_t c, input int unsigned rows,
                                             input int unsigned cols);
    return (n * addr_calc_t'(rows) + r) * addr_calc_t'(cols) + c;
  endfunction

endpackage

// File: rtl/conv_tile_cnt.sv
// Four-level tile origin counter: m innermost, then n, c, r.
// Each level steps by its tile size, wraps to 0 and carries into the next.
module conv_tile_cnt
  import conv_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned N  = DEF_N,
  parameter int unsigned M  = DEF_M,
  parameter int unsigned R  = DEF_R,
  parameter int unsigned C  = DEF_C,
  parameter int unsigned Tn = DEF_TN,
  parameter int unsigned Tm = DEF_TM,
  parameter int unsigned Tr = DEF_TR,
  parameter int unsigned Tc = DEF_TC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] cnt_n,
  output logic [AW-1:0] cnt_m,
  output logic [AW-1:0] cnt_r,
  output logic [AW-1:0] cnt_c,
  output logic [AW-1:0] nxt_n,
  output logic [AW-1:0] nxt_m,
  output logic [AW-1:0] nxt_r,
  output logic [AW-1:0] nxt_c,
  output logic          last
);

  localparam logic [AW-1:0] N_LAST = AW'((tile_count(N, Tn) - 1) * Tn);
  localparam logic [AW-1:0] M_LAST = AW'((tile_count(M, Tm) - 1) * Tm);
  localparam logic [AW-1:0] R_LAST = AW'((tile_count(R, Tr) - 1) * Tr);
  localparam logic [AW-1:0] C_LAST = AW'((tile_count(C, Tc) - 1) * Tc);
  localparam logic [AW-1:0] N_STEP = AW'(Tn);
  localparam logic [AW-1:0] M_STEP = AW'(Tm);
  localparam logic [AW-1:0] R_STEP = AW'(Tr);
  localparam logic [AW-1:0] C_STEP = AW'(Tc);

  logic m_wrap, n_wrap, c_wrap, r_wrap;

  assign m_wrap = (cnt_m == M_LAST);
  assign n_wrap = (cnt_n == N_LAST);
  assign c_wrap = (cnt_c == C_LAST);
  assign r_wrap = (cnt_r == R_LAST);
  assign last   = m_wrap && n_wrap && c_wrap && r_wrap;

  // Next origin: increment innermost level, ripple carries outward on wrap.
  always_comb begin
    nxt_m = cnt_m + M_STEP;
    nxt_n = cnt_n;
    nxt_c = cnt_c;
    nxt_r = cnt_r;
    if (m_wrap) begin
      nxt_m = '0;
      nxt_n = cnt_n + N_STEP;
      if (n_wrap) begin
        nxt_n = '0;
        nxt_c = cnt_c + C_STEP;
        if (c_wrap) begin
          nxt_c = '0;
          nxt_r = cnt_r + R_STEP;
          if (r_wrap) begin
            nxt_r = '0;
          end
        end
      end
    end
  end

  // Origin registers: cleared while idle, advanced once per finished tile.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_n <= '0;
      cnt_m <= '0;
      cnt_r <= '0;
      cnt_c <= '0;
    end else if (adv) begin
      cnt_n <= nxt_n;
      cnt_m <= nxt_m;
      cnt_r <= nxt_r;
      cnt_c <= nxt_c;
    end
  end

endmodule

// File: rtl/conv_tile_sched.sv
// Layer sequencer for conv_core: walks the layer tile by tile, running
// load -> compute -> store per tile and publishing tile origin and
// external-memory base addresses for the data movers.
module conv_tile_sched
  import conv_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned N  = DEF_N,
  parameter int unsigned M  = DEF_M,
  parameter int unsigned R  = DEF_R,
  parameter int unsigned C  = DEF_C,
  parameter int unsigned Tn = DEF_TN,
  parameter int unsigned Tm = DEF_TM,
  parameter int unsigned Tr = DEF_TR,
  parameter int unsigned Tc = DEF_TC,
  parameter int unsigned K  = DEF_K
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          tile_load_start,
  input  logic          tile_load_done,
  output logic          tile_comp_start,
  input  logic          tile_comp_done,
  output logic          tile_store_start,
  input  logic          tile_store_done,
  output logic [AW-1:0] tile_n,
  output logic [AW-1:0] tile_m,
  output logic [AW-1:0] tile_r,
  output logic [AW-1:0] tile_c,
  output logic [AW-1:0] in_fm_base,
  output logic [AW-1:0] weight_base,
  output logic [AW-1:0] out_fm_base
);

  if ((N % Tn) != 0 || (M % Tm) != 0 || (R % Tr) != 0 || (C % Tc) != 0) begin : g_tiling_err
    $error("conv_tile_sched: layer dimensions must be whole multiples of the tile sizes");
  end

  tile_state_t   state, state_nxt;
  logic          load_set, comp_set, store_set, fin_set;
  logic          last_tile;
  logic [AW-1:0] nxt_n, nxt_m, nxt_r, nxt_c;

  conv_tile_cnt #(
    .AW(AW), .N(N), .M(M), .R(R), .C(C),
    .Tn(Tn), .Tm(Tm), .Tr(Tr), .Tc(Tc)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_IDLE),
    .adv  (state == ST_NEXT),
    .cnt_n(tile_n),
    .cnt_m(tile_m),
    .cnt_r(tile_r),
    .cnt_c(tile_c),
    .nxt_n(nxt_n),
    .nxt_m(nxt_m),
    .nxt_r(nxt_r),
    .nxt_c(nxt_c),
    .last (last_tile)
  );

  assign busy = (state != ST_IDLE);

  // Next state and entry-pulse requests; a done only counts in its own wait state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (layer_start)     state_nxt = ST_LOAD;
      ST_LOAD:  if (tile_load_done)  state_nxt = ST_COMP;
      ST_COMP:  if (tile_comp_done)  state_nxt = ST_STORE;
      ST_STORE: if (tile_store_done) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = last_tile ? ST_FIN : ST_LOAD;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    load_set  = (state_nxt == ST_LOAD)  && (state != ST_LOAD);
    comp_set  = (state_nxt == ST_COMP)  && (state != ST_COMP);
    store_set = (state_nxt == ST_STORE) && (state != ST_STORE);
    fin_set   = (state_nxt == ST_FIN);
  end

  // State register; start/done pulses are registered so they coincide with state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      tile_load_start  <= 1'b0;
      tile_comp_start  <= 1'b0;
      tile_store_start <= 1'b0;
      layer_done       <= 1'b0;
    end else begin
      state            <= state_nxt;
      tile_load_start  <= load_set;
      tile_comp_start  <= comp_set;
      tile_store_start <= store_set;
      layer_done       <= fin_set;
    end
  end

  // Base addresses follow the counters: computed from the next origin while in NEXT.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      in_fm_base  <= '0;
      weight_base <= '0;
      out_fm_base <= '0;
    end else if (state == ST_NEXT) begin
      in_fm_base  <= AW'(in_fm_addr(addr_calc_t'(nxt_m), addr_calc_t'(nxt_r),
                                    addr_calc_t'(nxt_c), R, C));
      weight_base <= AW'(weight_addr(addr_calc_t'(nxt_n), addr_calc_t'(nxt_m), M, K));
      out_fm_base <= AW'(out_fm_addr(addr_calc_t'(nxt_n), addr_calc_t'(nxt_r),
                                     addr_calc_t'(nxt_c), R, C));
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: a multi-tile layer instance (32x32x64x16 in
// 16x16x32x16 tiles) plus a default single-tile instance.
module tb_conv_tile_sched;

  localparam int unsigned AW = 32;
  localparam int unsigned LN = 32, LM = 32, LR = 64, LC = 16;
  localparam int unsigned LTN = 16, LTM = 16, LTR = 32, LTC = 16, LK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic layer_start = 1'b0, tile_load_done = 1'b0, tile_comp_done = 1'b0, tile_store_done = 1'b0;
  logic layer_done, busy, tile_load_start, tile_comp_start, tile_store_start;
  logic [AW-1:0] tile_n, tile_m, tile_r, tile_c, in_fm_base, weight_base, out_fm_base;

  logic s_layer_start = 1'b0, s_load_done = 1'b0, s_comp_done = 1'b0, s_store_done = 1'b0;
  logic s_layer_done, s_busy, s_load_start, s_comp_start, s_store_start;
  logic [AW-1:0] s_n, s_m, s_r, s_c, s_in, s_w, s_out;

  conv_tile_sched #(
    .AW(AW), .N(LN), .M(LM), .R(LR), .C(LC),
    .Tn(LTN), .Tm(LTM), .Tr(LTR), .Tc(LTC), .K(LK)
  ) u_dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_done(layer_done), .busy(busy),
    .tile_load_start(tile_load_start), .tile_load_done(tile_load_done),
    .tile_comp_start(tile_comp_start), .tile_comp_done(tile_comp_done),
    .tile_store_start(tile_store_start), .tile_store_done(tile_store_done),
    .tile_n(tile_n), .tile_m(tile_m), .tile_r(tile_r), .tile_c(tile_c),
    .in_fm_base(in_fm_base), .weight_base(weight_base), .out_fm_base(out_fm_base)
  );

  conv_tile_sched u_single (
    .clk(clk), .rst(rst), .layer_start(s_layer_start), .layer_done(s_layer_done), .busy(s_busy),
    .tile_load_start(s_load_start), .tile_load_done(s_load_done),
    .tile_comp_start(s_comp_start), .tile_comp_done(s_comp_done),
    .tile_store_start(s_store_start), .tile_store_done(s_store_done),
    .tile_n(s_n), .tile_m(s_m), .tile_r(s_r), .tile_c(s_c),
    .in_fm_base(s_in), .weight_base(s_w), .out_fm_base(s_out)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int n_load = 0, n_comp = 0, n_store = 0, n_done = 0;
  int s_n_load = 0, s_n_comp = 0, s_n_store = 0, s_n_done = 0;

  typedef struct {
    logic [AW-1:0] n, m, r, c, inb, wb, outb;
  } tile_t;
  tile_t exp_q[$];
  logic [AW-1:0] obs_n[8], obs_m[8], obs_r[8], obs_in[8], obs_wb[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tile_load_start)  n_load   <= n_load + 1;
    if (tile_comp_start)  n_comp   <= n_comp + 1;
    if (tile_store_start) n_store  <= n_store + 1;
    if (layer_done)       n_done   <= n_done + 1;
    if (s_load_start)     s_n_load <= s_n_load + 1;
    if (s_comp_start)     s_n_comp <= s_n_comp + 1;
    if (s_store_start)    s_n_store <= s_n_store + 1;
    if (s_layer_done)     s_n_done <= s_n_done + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected tile sequence: r outermost, then c, n, m innermost.
  task automatic build_model;
    tile_t t;
    exp_q.delete();
    for (int r = 0; r < int'(LR); r += int'(LTR))
      for (int c = 0; c < int'(LC); c += int'(LTC))
        for (int n = 0; n < int'(LN); n += int'(LTN))
          for (int m = 0; m < int'(LM); m += int'(LTM)) begin
            t.n = n; t.m = m; t.r = r; t.c = c;
            t.inb  = AW'((m * LR + r) * LC + c);
            t.wb   = AW'((n * LM + m) * LK * LK);
            t.outb = AW'((n * LR + r) * LC + c);
            exp_q.push_back(t);
          end
  endtask

  function automatic logic dut_start(input int s);
    case (s)
      0:       return tile_load_start;
      1:       return tile_comp_start;
      default: return tile_store_start;
    endcase
  endfunction

  function automatic logic single_start(input int s);
    case (s)
      0:       return s_load_start;
      1:       return s_comp_start;
      default: return s_store_start;
    endcase
  endfunction

  task automatic set_dut_done(input int s, input logic v);
    case (s)
      0:       tile_load_done = v;
      1:       tile_comp_done = v;
      default: tile_store_done = v;
    endcase
  endtask

  task automatic set_single_done(input int s, input logic v);
    case (s)
      0:       s_load_done = v;
      1:       s_comp_done = v;
      default: s_store_done = v;
    endcase
  endtask

  task automatic start_layer;
    layer_start = 1'b1;
    tick;
    layer_start = 1'b0;
    checks++;
    if (tile_load_start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL layer_start_accept: load_start=%b busy=%b, required 1 1", tile_load_start, busy);
    end
    last_load_cyc = cyc;
  endtask

  // Runs one tile starting in the cycle its first_stage start pulse is visible.
  // mode 1: zero-wait engines; otherwise random ack delay 1..6 cycles.
  task automatic do_tile(input int idx, input int mode, input int first_stage,
                         input bit poke, input bit stop_store);
    tile_t e;
    int d;
    logic [2:0] starts;
    logic [2:0] want;
    e = exp_q[idx];
    if (first_stage == 0) begin
      obs_n[idx] = tile_n; obs_m[idx] = tile_m; obs_r[idx] = tile_r;
      obs_in[idx] = in_fm_base; obs_wb[idx] = weight_base;
    end
    for (int s = first_stage; s < 3; s++) begin
      checks++;
      if (tile_n !== e.n || tile_m !== e.m || tile_r !== e.r || tile_c !== e.c ||
          in_fm_base !== e.inb || weight_base !== e.wb || out_fm_base !== e.outb) begin
        failures++;
        $display("FAIL tile_origin idx=%0d stage=%0d got n/m/r/c=%0d/%0d/%0d/%0d in/w/out=%0d/%0d/%0d required %0d/%0d/%0d/%0d %0d/%0d/%0d",
                 idx, s, tile_n, tile_m, tile_r, tile_c, in_fm_base, weight_base, out_fm_base,
                 e.n, e.m, e.r, e.c, e.inb, e.wb, e.outb);
      end
      if (s == 2 && stop_store) return;
      d = (mode == 1) ? 1 : int'($urandom_range(6, 1));
      for (int k = 1; k <= d; k++) begin
        tick;
        starts = {tile_load_start, tile_comp_start, tile_store_start};
        checks++;
        if (starts !== 3'b000 || layer_done !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL wait_quiet idx=%0d stage=%0d starts=%b done=%b busy=%b, required 000 0 1",
                   idx, s, starts, layer_done, busy);
        end
        layer_start = (poke && s == 1 && k == 1);
        if (k == d) set_dut_done(s, 1'b1);
      end
      tick;
      set_dut_done(s, 1'b0);
      layer_start = 1'b0;
      starts = {tile_load_start, tile_comp_start, tile_store_start};
      want = (s == 0) ? 3'b010 : (s == 1) ? 3'b001 : 3'b000;
      checks++;
      if (starts !== want || layer_done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stage_handoff idx=%0d stage=%0d starts=%b done=%b busy=%b, required %b 0 1",
                 idx, s, starts, layer_done, busy, want);
      end
    end
    tick;
    checks++;
    if (idx == exp_q.size() - 1) begin
      if (layer_done !== 1'b1 || tile_load_start !== 1'b0) begin
        failures++;
        $display("FAIL layer_done_pulse done=%b load_start=%b, required 1 0", layer_done, tile_load_start);
      end
    end else begin
      if (tile_load_start !== 1'b1 || layer_done !== 1'b0) begin
        failures++;
        $display("FAIL next_tile_load idx=%0d load_start=%b done=%b, required 1 0",
                 idx, tile_load_start, layer_done);
      end
      if (mode == 1) begin
        checks++;
        if (cyc - last_load_cyc != 7) begin
          failures++;
          $display("FAIL tile_period idx=%0d got %0d cycles, required 7", idx, cyc - last_load_cyc);
        end
      end
      last_load_cyc = cyc;
    end
  endtask

  task automatic run_layer(input int mode);
    start_layer();
    for (int i = 0; i < exp_q.size(); i++) do_tile(i, mode, 0, 1'b0, 1'b0);
    tick;
    checks++;
    if (busy !== 1'b0 || layer_done !== 1'b0) begin
      failures++;
      $display("FAIL layer_idle busy=%b done=%b, required 0 0", busy, layer_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({layer_done, busy, tile_load_start, tile_comp_start, tile_store_start, tile_n, tile_m,
         tile_r, tile_c, in_fm_base, weight_base, out_fm_base} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b n=%0d m=%0d in=%0d, required all 0", busy, tile_n, tile_m, in_fm_base);
    end
    checks++;
    if ({s_layer_done, s_busy, s_load_start, s_comp_start, s_store_start, s_n, s_m, s_r, s_c,
         s_in, s_w, s_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_single busy=%b, required all 0", s_busy);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_tile;
    int b_load, b_comp, b_store, b_done;
    b_load = s_n_load; b_comp = s_n_comp; b_store = s_n_store; b_done = s_n_done;
    s_layer_start = 1'b1;
    tick;
    s_layer_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (single_start(s) !== 1'b1 || {s_n, s_m, s_r, s_c, s_in, s_w, s_out} !== '0) begin
        failures++;
        $display("FAIL single_stage_start stage=%0d start=%b in/w/out=%0d/%0d/%0d, required 1 0/0/0",
                 s, single_start(s), s_in, s_w, s_out);
      end
      for (int k = 1; k <= 5; k++) begin
        tick;
        if (k == 5) set_single_done(s, 1'b1);
      end
      tick;
      set_single_done(s, 1'b0);
    end
    checks++;
    if (s_layer_done !== 1'b0 || s_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_next done=%b busy=%b, required 0 1", s_layer_done, s_busy);
    end
    tick;
    checks++;
    if (s_layer_done !== 1'b1) begin
      failures++;
      $display("FAIL single_layer_done got %b, required 1", s_layer_done);
    end
    tick;
    checks++;
    if (s_layer_done !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle done=%b busy=%b, required 0 0", s_layer_done, s_busy);
    end
    tick;
    checks++;
    if (s_n_load - b_load != 1 || s_n_comp - b_comp != 1 || s_n_store - b_store != 1 ||
        s_n_done - b_done != 1) begin
      failures++;
      $display("FAIL single_pulse_counts load/comp/store/done=%0d/%0d/%0d/%0d, required 1/1/1/1",
               s_n_load - b_load, s_n_comp - b_comp, s_n_store - b_store, s_n_done - b_done);
    end
  endtask

  task automatic test_order;
    int b_load, b_comp, b_store, b_done;
    b_load = n_load; b_comp = n_comp; b_store = n_store; b_done = n_done;
    run_layer(0);
    tick;
    checks++;
    if (n_load - b_load != 8 || n_comp - b_comp != 8 || n_store - b_store != 8 || n_done - b_done != 1) begin
      failures++;
      $display("FAIL order_pulse_counts load/comp/store/done=%0d/%0d/%0d/%0d, required 8/8/8/1",
               n_load - b_load, n_comp - b_comp, n_store - b_store, n_done - b_done);
    end
    checks++;
    if (obs_m[1] !== 32'd16 || obs_n[1] !== 32'd0 || obs_m[2] !== 32'd0 || obs_n[2] !== 32'd16 ||
        obs_m[3] !== 32'd16 || obs_n[3] !== 32'd16 || obs_r[4] !== 32'd32 || obs_m[4] !== 32'd0) begin
      failures++;
      $display("FAIL order_sequence m1=%0d n2=%0d m3=%0d n3=%0d r4=%0d, required 16 16 16 16 32",
               obs_m[1], obs_n[2], obs_m[3], obs_n[3], obs_r[4]);
    end
    checks++;
    if (obs_wb[1] !== 32'd144) begin
      failures++;
      $display("FAIL order_weight_base tile2 got %0d, required 144", obs_wb[1]);
    end
    checks++;
    if (obs_in[4] !== 32'd512) begin
      failures++;
      $display("FAIL order_in_fm_base tile5 got %0d, required 512", obs_in[4]);
    end
  endtask

  task automatic test_spurious_done;
    int b_comp;
    start_layer();
    b_comp = n_comp;
    tick;
    tile_comp_done = 1'b1;
    tick;
    tile_comp_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tile_comp_start !== 1'b0 || tile_store_start !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL spurious_comp_done comp_start=%b store_start=%b busy=%b, required 0 0 1",
                 tile_comp_start, tile_store_start, busy);
      end
      tick;
    end
    checks++;
    if (n_comp != b_comp) begin
      failures++;
      $display("FAIL spurious_comp_count got %0d extra, required 0", n_comp - b_comp);
    end
    tile_load_done = 1'b1;
    tick;
    tile_load_done = 1'b0;
    checks++;
    if (tile_comp_start !== 1'b1) begin
      failures++;
      $display("FAIL spurious_then_load comp_start=%b, required 1", tile_comp_start);
    end
    do_tile(0, 0, 1, 1'b0, 1'b0);
    for (int i = 1; i < exp_q.size(); i++) do_tile(i, 0, 0, 1'b0, 1'b0);
    tick;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_layer_end busy=%b, required 0", busy);
    end
  endtask

  task automatic test_start_while_busy;
    int b_load, b_done;
    b_load = n_load; b_done = n_done;
    start_layer();
    do_tile(0, 0, 0, 1'b1, 1'b0);
    for (int i = 1; i < exp_q.size(); i++) do_tile(i, 0, 0, 1'b0, 1'b0);
    layer_start = 1'b1;
    tick;
    layer_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy !== 1'b0 || tile_load_start !== 1'b0) begin
        failures++;
        $display("FAIL start_on_done busy=%b load_start=%b, required 0 0", busy, tile_load_start);
      end
      tick;
    end
    checks++;
    if (n_load - b_load != 8 || n_done - b_done != 1) begin
      failures++;
      $display("FAIL start_while_busy_counts load=%0d done=%0d, required 8 1", n_load - b_load, n_done - b_done);
    end
  endtask

  task automatic test_reset_mid_layer;
    start_layer();
    for (int i = 0; i < 3; i++) do_tile(i, 0, 0, 1'b0, 1'b0);
    do_tile(3, 0, 0, 1'b0, 1'b1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({layer_done, busy, tile_load_start, tile_comp_start, tile_store_start, tile_n, tile_m,
         tile_r, tile_c, in_fm_base, weight_base, out_fm_base} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs busy=%b n=%0d m=%0d r=%0d w=%0d, required all 0",
               busy, tile_n, tile_m, tile_r, weight_base);
    end
    tile_store_done = 1'b1;
    tick;
    tile_store_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy !== 1'b0 || tile_load_start !== 1'b0 || layer_done !== 1'b0 || tile_n !== '0) begin
        failures++;
        $display("FAIL late_store_done busy=%b load_start=%b done=%b, required 0 0 0",
                 busy, tile_load_start, layer_done);
      end
      tick;
    end
    run_layer(0);
  endtask

  task automatic test_zero_wait;
    int b_load, b_store, b_done;
    b_load = n_load; b_store = n_store; b_done = n_done;
    run_layer(1);
    tick;
    checks++;
    if (n_load - b_load != 8 || n_store - b_store != 8 || n_done - b_done != 1) begin
      failures++;
      $display("FAIL zero_wait_counts load/store/done=%0d/%0d/%0d, required 8/8/1",
               n_load - b_load, n_store - b_store, n_done - b_done);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_single_tile();
    test_order();
    test_spurious_done();
    test_start_while_busy();
    test_reset_mid_layer();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
